// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding control unit:
// forwarding codes, multiply/divide op encodings and timing-field widths.
package hazard_pkg;

  localparam int REG_W  = 5;
  localparam int TNEW_W = 2;
  localparam int TUSE_W = 2;

  localparam logic [1:0] FW_NONE   = 2'b00;
  localparam logic [1:0] FW_M_OR_W = 2'b01;
  localparam logic [1:0] FW_E_OR_M = 2'b10;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10,
    MD_HILO = 2'b11
  } md_op_e;

  // A producer's remaining latency after it advances one stage.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // True when a pending write to src cannot be ready by the time it is used.
  function automatic logic src_hazard(
    input logic [REG_W-1:0]  src,
    input logic [TUSE_W-1:0] tuse,
    input logic [REG_W-1:0]  e_a3,
    input logic [TNEW_W-1:0] e_tnew,
    input logic [REG_W-1:0]  m_a3,
    input logic [TNEW_W-1:0] m_tnew
  );
    return (src != '0) &&
           (((e_a3 == src) && (e_tnew > tuse)) ||
            ((m_a3 == src) && (m_tnew > tuse)));
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Selects a forwarding source for one operand from two prioritized producer
// slots; the higher-priority slot wins when both match.
module fwd_match
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] i_src,
  input  logic [REG_W-1:0] i_a3_hi,
  input  logic             i_rdy_hi,
  input  logic [REG_W-1:0] i_a3_lo,
  input  logic             i_rdy_lo,
  output logic [1:0]       o_sel
);

  always_comb begin
    o_sel = FW_NONE;
    if (i_src != '0) begin
      if ((i_a3_hi == i_src) && i_rdy_hi) begin
        o_sel = FW_E_OR_M;
      end else if ((i_a3_lo == i_src) && i_rdy_lo) begin
        o_sel = FW_M_OR_W;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding control: shadow scoreboard of E/M/W producers, stall and
// forwarding decisions. Optional MDU busy interlock under HAZARD_MDU_STALL_EN.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_W-1:0]  D_rs,
  input  logic [REG_W-1:0]  D_rt,
  input  logic [TUSE_W-1:0] D_Tuse_rs,
  input  logic [TUSE_W-1:0] D_Tuse_rt,
  input  logic [REG_W-1:0]  D_A3,
  input  logic [TNEW_W-1:0] D_Tnew,
  input  logic [1:0]        D_md_op,
  output logic [1:0]        FW_sel_rs_D,
  output logic [1:0]        FW_sel_rt_D,
  output logic [1:0]        FW_sel_rs_E,
  output logic [1:0]        FW_sel_rt_E,
  output logic              stall,
  output logic              E_clr,
  output logic              md_busy
);

  logic [REG_W-1:0]  r_e_a3;
  logic [TNEW_W-1:0] r_e_tnew;
  logic [REG_W-1:0]  r_e_rs;
  logic [REG_W-1:0]  r_e_rt;
  logic [REG_W-1:0]  r_m_a3;
  logic [TNEW_W-1:0] r_m_tnew;
  logic [REG_W-1:0]  r_w_a3;

  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall_md;
  logic w_stall;
  logic w_md_busy;
  logic w_e_rdy;
  logic w_m_rdy;

  assign w_stall_rs = src_hazard(D_rs, D_Tuse_rs, r_e_a3, r_e_tnew, r_m_a3, r_m_tnew);
  assign w_stall_rt = src_hazard(D_rt, D_Tuse_rt, r_e_a3, r_e_tnew, r_m_a3, r_m_tnew);
  assign w_stall    = w_stall_rs | w_stall_rt | w_stall_md;

  assign stall   = w_stall;
  assign E_clr   = w_stall;
  assign md_busy = w_md_busy;

  // A stalled D instruction is replaced by a bubble so it never forwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e_a3   <= '0;
      r_e_tnew <= '0;
      r_e_rs   <= '0;
      r_e_rt   <= '0;
      r_m_a3   <= '0;
      r_m_tnew <= '0;
      r_w_a3   <= '0;
    end else begin
      if (w_stall) begin
        r_e_a3   <= '0;
        r_e_tnew <= '0;
        r_e_rs   <= '0;
        r_e_rt   <= '0;
      end else begin
        r_e_a3   <= D_A3;
        r_e_tnew <= D_Tnew;
        r_e_rs   <= D_rs;
        r_e_rt   <= D_rt;
      end
      r_m_a3   <= r_e_a3;
      r_m_tnew <= tnew_dec(r_e_tnew);
      r_w_a3   <= r_m_a3;
    end
  end

`ifdef HAZARD_MDU_STALL_EN
  localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int MD_W   = $clog2(MD_MAX + 1);

  logic [MD_W-1:0] r_md_cnt;
  logic [1:0]      r_e_md_op;
  logic            w_d_start;
  logic            w_e_start;

  assign w_d_start  = (D_md_op == MD_MULT) || (D_md_op == MD_DIV);
  assign w_e_start  = (r_e_md_op == MD_MULT) || (r_e_md_op == MD_DIV);
  assign w_md_busy  = (r_md_cnt != '0) || w_e_start;
  assign w_stall_md = (D_md_op != MD_NONE) && w_md_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_md_cnt  <= '0;
      r_e_md_op <= MD_NONE;
    end else begin
      r_e_md_op <= w_stall ? MD_NONE : D_md_op;
      if (w_d_start && !w_stall) begin
        r_md_cnt <= (D_md_op == MD_MULT) ? MD_W'(MULT_CYC) : MD_W'(DIV_CYC);
      end else if (r_md_cnt != '0) begin
        r_md_cnt <= r_md_cnt - 1'b1;
      end
    end
  end
`else
  logic w_unused_md;

  assign w_unused_md = ^{D_md_op, MULT_CYC[0], DIV_CYC[0]};
  assign w_md_busy   = 1'b0;
  assign w_stall_md  = 1'b0;
`endif

  assign w_e_rdy = (r_e_tnew == '0);
  assign w_m_rdy = (r_m_tnew == '0);

  // D stage: E over M; W reaches D through GRF write-through.
  fwd_match u_fwd_rs_d (
    .i_src    (D_rs),
    .i_a3_hi  (r_e_a3),
    .i_rdy_hi (w_e_rdy),
    .i_a3_lo  (r_m_a3),
    .i_rdy_lo (w_m_rdy),
    .o_sel    (FW_sel_rs_D)
  );

  fwd_match u_fwd_rt_d (
    .i_src    (D_rt),
    .i_a3_hi  (r_e_a3),
    .i_rdy_hi (w_e_rdy),
    .i_a3_lo  (r_m_a3),
    .i_rdy_lo (w_m_rdy),
    .o_sel    (FW_sel_rt_D)
  );

  // E stage: M over W; a W-slot value is always final.
  fwd_match u_fwd_rs_e (
    .i_src    (r_e_rs),
    .i_a3_hi  (r_m_a3),
    .i_rdy_hi (w_m_rdy),
    .i_a3_lo  (r_w_a3),
    .i_rdy_lo (1'b1),
    .o_sel    (FW_sel_rs_E)
  );

  fwd_match u_fwd_rt_e (
    .i_src    (r_e_rt),
    .i_a3_hi  (r_m_a3),
    .i_rdy_hi (w_m_rdy),
    .i_a3_lo  (r_w_a3),
    .i_rdy_lo (1'b1),
    .o_sel    (FW_sel_rt_E)
  );

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: producer/consumer table, reset and MDU sequences,
// and random stimulus against an age-based pipeline model.
module tb_hazard_fwd_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef HAZARD_MDU_STALL_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] D_rs = '0, D_rt = '0, D_A3 = '0;
  logic [1:0] D_Tuse_rs = '0, D_Tuse_rt = '0, D_Tnew = '0, D_md_op = '0;
  logic [1:0] FW_sel_rs_D, FW_sel_rt_D, FW_sel_rs_E, FW_sel_rt_E;
  logic       stall, E_clr, md_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk(clk), .reset_n(reset_n),
    .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_A3(D_A3), .D_Tnew(D_Tnew), .D_md_op(D_md_op),
    .FW_sel_rs_D(FW_sel_rs_D), .FW_sel_rt_D(FW_sel_rt_D),
    .FW_sel_rs_E(FW_sel_rs_E), .FW_sel_rt_E(FW_sel_rt_E),
    .stall(stall), .E_clr(E_clr), .md_busy(md_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] outs();
    return {FW_sel_rs_D, FW_sel_rt_D, FW_sel_rs_E, FW_sel_rt_E, stall, E_clr, md_busy};
  endfunction

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tu_rs,
                       input logic [1:0] tu_rt, input logic [4:0] a3, input logic [1:0] tnew,
                       input logic [1:0] md);
    D_rs = rs; D_rt = rt; D_Tuse_rs = tu_rs; D_Tuse_rt = tu_rt;
    D_A3 = a3; D_Tnew = tnew; D_md_op = md;
  endtask

  // Leaves time at negedge+2 with reset released and D idle.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0);
    #1 reset_n = 1'b1;
    #1;
  endtask

  // Two-instruction producer/consumer cases.
  typedef struct {
    logic [4:0] a3;
    logic [1:0] tnew;
    logic [4:0] src;
    logic [1:0] tuse;
    bit         use_rt;
    int         stalls;
    logic [1:0] fw_d;
    logic [1:0] fw_e;
  } vec_t;

  vec_t vecs[11];

  // Model: each slot remembers the Tnew it had when it left D; remaining
  // latency is that minus the number of stages travelled beyond E.
  typedef struct {
    logic [4:0] a3;
    int         tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } instr_t;

  instr_t pipe[3];
  int     cyc;
  int     md_free;

  function automatic int rem_tnew(input int stage);
    if (stage >= 2) return 0;
    return (pipe[stage].tnew > stage) ? pipe[stage].tnew - stage : 0;
  endfunction

  function automatic logic [1:0] exp_fw_d(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (pipe[0].a3 == src && rem_tnew(0) == 0) return 2'b10;
    if (pipe[1].a3 == src && rem_tnew(1) == 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] exp_fw_e(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (pipe[1].a3 == src && rem_tnew(1) == 0) return 2'b10;
    if (pipe[2].a3 == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_src_stall(input logic [4:0] src, input int tuse);
    for (int s = 0; s < 2; s++)
      if (src != 0 && pipe[s].a3 == src && rem_tnew(s) > tuse) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mdu_seq(input logic [1:0] start_op, input int exp_stalls, input string name);
    int n;
    do_reset();
    set_d(0, 0, 0, 0, 0, 0, start_op);
    @(posedge clk); #1;
    set_d(0, 0, 0, 0, 0, 0, 2'b11);
    @(negedge clk);
    check({name, "_busy"}, md_busy, MDU_EN);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (!stall) break;
      n++;
      @(posedge clk); #1;
    end
    check({name, "_stalls"}, n, exp_stalls);
  endtask

  initial begin
    logic [1:0] fw_d_act;
    int         nst;
    bit         st, busy;
    logic [10:0] exp_o;

    //             a3  tnew src tuse rt stalls fw_d   fw_e
    vecs[0]  = '{5'd8,  2'd2, 5'd8,  2'd1, 1'b0, 1, 2'b00, 2'b01}; // lw then add
    vecs[1]  = '{5'd8,  2'd2, 5'd8,  2'd0, 1'b0, 2, 2'b00, 2'b00}; // load-use, Tuse 0
    vecs[2]  = '{5'd9,  2'd1, 5'd9,  2'd0, 1'b0, 1, 2'b01, 2'b01}; // addu then beq
    vecs[3]  = '{5'd31, 2'd0, 5'd31, 2'd0, 1'b0, 0, 2'b10, 2'b10}; // jal then jr
    vecs[4]  = '{5'd0,  2'd2, 5'd0,  2'd0, 1'b0, 0, 2'b00, 2'b00}; // register zero
    vecs[5]  = '{5'd5,  2'd2, 5'd6,  2'd0, 1'b0, 0, 2'b00, 2'b00}; // no match
    vecs[6]  = '{5'd7,  2'd1, 5'd7,  2'd1, 1'b0, 0, 2'b00, 2'b10};
    vecs[7]  = '{5'd7,  2'd2, 5'd7,  2'd2, 1'b0, 0, 2'b00, 2'b00};
    vecs[8]  = '{5'd4,  2'd3, 5'd4,  2'd2, 1'b0, 1, 2'b00, 2'b01};
    vecs[9]  = '{5'd9,  2'd1, 5'd9,  2'd0, 1'b1, 1, 2'b01, 2'b01};
    vecs[10] = '{5'd31, 2'd0, 5'd31, 2'd0, 1'b1, 0, 2'b10, 2'b10};

    // Reset state, with live D inputs present.
    reset_n = 1'b0;
    set_d(5, 7, 0, 0, 3, 2, 2'b11);
    #1 check("reset_outs", outs(), 11'd0);
    do_reset();
    set_d(5, 7, 0, 0, 3, 2, 0);
    #1 check("post_reset_outs", outs(), 11'd0);

    foreach (vecs[i]) begin
      do_reset();
      set_d(0, 0, 0, 0, vecs[i].a3, vecs[i].tnew, 0);
      @(posedge clk); #1;
      if (vecs[i].use_rt) set_d(0, vecs[i].src, 0, vecs[i].tuse, 0, 0, 0);
      else                set_d(vecs[i].src, 0, vecs[i].tuse, 0, 0, 0, 0);
      nst = 0;
      fw_d_act = 2'bxx;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        check($sformatf("vec%0d_eclr", i), E_clr, stall);
        if (!stall) begin
          fw_d_act = vecs[i].use_rt ? FW_sel_rt_D : FW_sel_rs_D;
          break;
        end
        nst++;
        @(posedge clk); #1;
      end
      check($sformatf("vec%0d_stalls", i), nst, vecs[i].stalls);
      check($sformatf("vec%0d_fw_d", i), fw_d_act, vecs[i].fw_d);
      @(posedge clk); #1;
      set_d(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check($sformatf("vec%0d_fw_e", i), vecs[i].use_rt ? FW_sel_rt_E : FW_sel_rs_E, vecs[i].fw_e);
    end

    // Asynchronous reset while a load-use stall is active.
    do_reset();
    set_d(0, 0, 0, 0, 8, 2, 0);
    @(posedge clk); #1;
    set_d(8, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("midstall_pre", stall, 1'b1);
    #1 reset_n = 1'b0;
    #1 check("midstall_rst", outs(), 11'd0);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_edge", stall, 1'b0);

    // div/mult followed by an mfhi-style HI/LO access.
    mdu_seq(2'b10, MDU_EN ? DIV_N : 0, "mdu_div");
    mdu_seq(2'b01, MDU_EN ? MULT_N : 0, "mdu_mult");

    // Random stimulus against the model.
    do_reset();
    @(posedge clk); #1;
    foreach (pipe[s]) pipe[s] = '{5'd0, 0, 5'd0, 5'd0};
    cyc = 0;
    md_free = 0;
    for (int n = 0; n < 2000; n++) begin
      D_rs = 5'($urandom_range(0, 3));
      D_rt = 5'($urandom_range(0, 3));
      D_A3 = 5'($urandom_range(0, 3));
      D_Tnew = 2'($urandom_range(0, 3));
      D_Tuse_rs = 2'($urandom_range(0, 3));
      D_Tuse_rt = 2'($urandom_range(0, 3));
      D_md_op = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      @(negedge clk);
      busy = MDU_EN && (cyc < md_free);
      st = exp_src_stall(D_rs, int'(D_Tuse_rs)) || exp_src_stall(D_rt, int'(D_Tuse_rt)) ||
           (D_md_op != 2'b00 && busy);
      exp_o = {exp_fw_d(D_rs), exp_fw_d(D_rt), exp_fw_e(pipe[0].rs), exp_fw_e(pipe[0].rt),
               st, st, busy};
      check("random", outs(), exp_o);
      @(posedge clk);
      if (!st && MDU_EN && (D_md_op == 2'b01 || D_md_op == 2'b10))
        md_free = cyc + 1 + ((D_md_op == 2'b01) ? MULT_N : DIV_N);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (st) pipe[0] = '{5'd0, 0, 5'd0, 5'd0};
      else    pipe[0] = '{D_A3, int'(D_Tnew), D_rs, D_rt};
      cyc++;
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
